// File: rtl/hex_disp_pkg.sv
// Shared types and helpers for the scrolling seven-segment display controller.
package hex_disp_pkg;

   typedef enum logic [1:0] {IDLE, SCROLL, PAUSE} state_t;

   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // Active-low segments g..a in [6:0]; the decimal point in [7] is always off.
   function automatic logic [7:0] seg7_encode(input logic [3:0] nibble, input logic blank);
      logic [6:0] seg;
      case (nibble)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         default: seg = 7'h0E;
      endcase
      seg7_encode = blank ? SEG_BLANK : {1'b1, seg};
   endfunction

endpackage

// File: rtl/key_cond.sv
// Pushbutton conditioner: 2-flop synchronizer, optional counter debounce
// (HEX_DEBOUNCE_EN), and a single-cycle press pulse on the conditioned 1->0 edge.
module key_cond #(
   parameter int unsigned DB_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pin,
   output logic press
);

   logic sync1_q, sync2_q;
   logic level;
   logic level_prev_q;
   logic press_q;

   // Synchronize the asynchronous pin; released (1) out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= pin;
         sync2_q <= sync1_q;
      end
   end

`ifdef HEX_DEBOUNCE_EN
   localparam int unsigned CW = $clog2(DB_CYCLES + 1);

   logic [CW-1:0] db_cnt_q;
   logic          db_level_q;

   // Level follows the synchronized pin only after DB_CYCLES consecutive differing samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_cnt_q   <= '0;
         db_level_q <= 1'b1;
      end else if (sync2_q == db_level_q) begin
         db_cnt_q <= '0;
      end else if (db_cnt_q == CW'(DB_CYCLES - 1)) begin
         db_cnt_q   <= '0;
         db_level_q <= sync2_q;
      end else begin
         db_cnt_q <= db_cnt_q + CW'(1);
      end
   end

   assign level = db_level_q;
`else
   logic unused_db;
   assign unused_db = ^DB_CYCLES;
   assign level     = sync2_q;
`endif

   // Registered falling-edge detect so each press is exactly one cycle wide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_prev_q <= 1'b1;
         press_q      <= 1'b0;
      end else begin
         level_prev_q <= level;
         press_q      <= level_prev_q & ~level;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/hex_scroll_ctrl.sv
// Six-digit seven-segment message controller: buffers hex nibbles, scrolls
// messages longer than six digits, KEY0 pause/resume, KEY1 step, KEY2 clear.
// Define HEX_DEBOUNCE_EN to add counter debounce to the pushbuttons.
module hex_scroll_ctrl
   import hex_disp_pkg::*;
#(
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned SCROLL_DIV = 25_000_000,
   parameter int unsigned DB_CYCLES  = 1_000_000
) (
   input  logic                     clk_clk,
   input  logic                     reset_reset_n,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   input  logic [4:0]               wr_data,
   input  logic                     clear,
   input  logic [3:0]               pushbuttons_export,
   output logic [$clog2(DEPTH):0]   msg_count,
   output logic                     paused,
   output logic [31:0]              hex3_hex0_export,
   output logic [15:0]              hex5_hex4_export
);

   localparam int unsigned WW = $clog2(DEPTH);
   localparam int unsigned CW = WW + 1;
   localparam int unsigned SW = CW + 1;
   localparam int unsigned TW = $clog2(SCROLL_DIV);

   logic [4:0]    msg_buf_q [DEPTH];
   logic [CW-1:0] count_q, count_d;
   logic [WW-1:0] win_q, win_d, win_inc;
   logic [TW-1:0] timer_q, timer_d;
   state_t        state_q, state_d;
   logic          ready_en_q;
   logic [7:0]    hex_q [6];
   logic [7:0]    hex_d [6];
   logic [3:0]    key_press;
   logic          clr, wr_accept;
   logic          unused_key3;

   for (genvar k = 0; k < 4; k++) begin : g_key
      key_cond #(
         .DB_CYCLES(DB_CYCLES)
      ) u_key (
         .clk  (clk_clk),
         .rst_n(reset_reset_n),
         .pin  (pushbuttons_export[k]),
         .press(key_press[k])
      );
   end

   assign unused_key3 = key_press[3];

   assign clr       = clear | key_press[2];
   assign wr_ready  = ready_en_q && (count_q < CW'(DEPTH)) && !clear && !key_press[2];
   assign wr_accept = wr_valid & wr_ready;
   assign count_d   = clr ? '0 : count_q + CW'(wr_accept);
   assign win_inc   = (CW'(win_q) + CW'(1) == count_q) ? '0 : win_q + WW'(1);

   // Scroll state machine; clear overrides everything, KEY0 outranks KEY1.
   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      timer_d = timer_q;
      if (clr) begin
         state_d = IDLE;
         win_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (count_q > CW'(6)) begin
                  state_d = SCROLL;
                  timer_d = '0;
               end
            end
            SCROLL: begin
               if (key_press[0]) begin
                  state_d = PAUSE;
               end else if (timer_q == TW'(SCROLL_DIV - 1)) begin
                  timer_d = '0;
                  win_d   = win_inc;
               end else begin
                  timer_d = timer_q + TW'(1);
               end
            end
            PAUSE: begin
               if (key_press[0]) begin
                  state_d = SCROLL;
               end else if (key_press[1]) begin
                  win_d = win_inc;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Control registers.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_q    <= IDLE;
         count_q    <= '0;
         win_q      <= '0;
         timer_q    <= '0;
         ready_en_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         win_q      <= win_d;
         timer_q    <= timer_d;
         ready_en_q <= 1'b1;
      end
   end

   // Message buffer: append at the current count.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         for (int i = 0; i < DEPTH; i++) msg_buf_q[i] <= '0;
      end else if (wr_accept) begin
         msg_buf_q[count_q[WW-1:0]] <= wr_data;
      end
   end

   // Digit d (0 = HEX5) shows entry (win + d) mod count; win + d < 2*count so one subtract wraps.
   for (genvar d = 0; d < 6; d++) begin : g_digit
      logic [SW-1:0] sum;
      logic [WW-1:0] idx;
      logic          valid;
      assign sum      = SW'(win_q) + SW'(d);
      assign idx      = (sum >= SW'(count_q)) ? WW'(sum - SW'(count_q)) : WW'(sum);
      assign valid    = (count_q > CW'(6)) || (CW'(d) < count_q);
      assign hex_d[d] = valid ? seg7_encode(msg_buf_q[idx][3:0], msg_buf_q[idx][4]) : SEG_BLANK;
   end

   // Registered digit outputs.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         for (int i = 0; i < 6; i++) hex_q[i] <= SEG_BLANK;
      end else begin
         for (int i = 0; i < 6; i++) hex_q[i] <= hex_d[i];
      end
   end

   assign hex5_hex4_export = {hex_q[0], hex_q[1]};
   assign hex3_hex0_export = {hex_q[2], hex_q[3], hex_q[4], hex_q[5]};
   assign msg_count        = count_q;
   assign paused           = (state_q == PAUSE);

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Self-checking bench for hex_scroll_ctrl: cycle model of the message/window
// behaviour plus directed literal checks. Honors HEX_DEBOUNCE_EN.
module tb_hex_scroll_ctrl;

   localparam int DEPTH = 16;
   localparam int DIV   = 8;
   localparam int DBC   = 4;
`ifdef HEX_DEBOUNCE_EN
   localparam int DB_N = DBC;
   localparam int LAT  = 4;
`else
   localparam int DB_N = 1;
   localparam int LAT  = 3;
`endif

   logic        clk, rst_n, wr_valid, wr_ready, clear, paused;
   logic [4:0]  wr_data, msg_count;
   logic [3:0]  keys;
   logic [31:0] hex30;
   logic [15:0] hex54;

   hex_scroll_ctrl #(
      .DEPTH     (DEPTH),
      .SCROLL_DIV(DIV),
      .DB_CYCLES (DBC)
   ) dut (
      .clk_clk           (clk),
      .reset_reset_n     (rst_n),
      .wr_valid          (wr_valid),
      .wr_ready          (wr_ready),
      .wr_data           (wr_data),
      .clear             (clear),
      .pushbuttons_export(keys),
      .msg_count         (msg_count),
      .paused            (paused),
      .hex3_hex0_export  (hex30),
      .hex5_hex4_export  (hex54)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit check_on = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
   logic [4:0] m_buf [DEPTH];
   int         m_count, m_win, m_mode, m_tick;   // mode: 0 idle, 1 scroll, 2 pause
   bit         m_ready;
   logic [7:0] m_hex [6];
   bit [7:0]   hist [3];
   bit         m_lvl [3];
   bit [7:0]   pend [3];
   bit         ev [3];
   bit         m_rdy, m_clr, differ;

   function automatic logic [7:0] enc(input logic [4:0] e);
      return e[4] ? 8'hFF : seg_tab[e[3:0]];
   endfunction

   function automatic logic [7:0] disp(input int d);
      if (m_count <= 6) return (d < m_count) ? enc(m_buf[d]) : 8'hFF;
      return enc(m_buf[(m_win + d) % m_count]);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_count = 0; m_win = 0; m_mode = 0; m_tick = 0; m_ready = 0;
         for (int d = 0; d < 6; d++) m_hex[d] = 8'hFF;
         for (int k = 0; k < 3; k++) begin
            hist[k] = '1; m_lvl[k] = 1; pend[k] = '0;
         end
      end else begin
         // A press acts LAT edges after the key has been seen low for DB_N samples.
         for (int k = 0; k < 3; k++) begin
            ev[k]   = pend[k][0];
            pend[k] = pend[k] >> 1;
            hist[k] = {hist[k][6:0], keys[k]};
            differ  = 1;
            for (int i = 0; i < DB_N; i++) if (hist[k][i] == m_lvl[k]) differ = 0;
            if (differ) begin
               m_lvl[k] = ~m_lvl[k];
               if (!m_lvl[k]) pend[k][LAT-1] = 1'b1;
            end
         end
         m_rdy = m_ready && m_count < DEPTH && !clear && !ev[2];
         m_clr = clear || ev[2];
         for (int d = 0; d < 6; d++) m_hex[d] = disp(d);
         m_ready = 1;
         if (m_clr) begin
            m_count = 0; m_win = 0; m_mode = 0;
         end else begin
            if (m_mode == 0) begin
               if (m_count > 6) begin m_mode = 1; m_tick = 0; end
            end else if (m_mode == 1) begin
               if (ev[0]) m_mode = 2;
               else if (m_tick == DIV - 1) begin m_tick = 0; m_win = (m_win + 1) % m_count; end
               else m_tick++;
            end else begin
               if (ev[0]) m_mode = 1;
               else if (ev[1]) m_win = (m_win + 1) % m_count;
            end
            if (wr_valid && m_rdy) begin
               m_buf[m_count] = wr_data;
               m_count++;
            end
         end
      end
   end

   // Compare every output against the model each cycle.
   always @(posedge clk) begin
      #1;
      if (check_on) begin
         chk("hex5_hex4", hex54, {m_hex[0], m_hex[1]});
         chk("hex3_hex0", hex30, {m_hex[2], m_hex[3], m_hex[4], m_hex[5]});
         chk("msg_count", msg_count, m_count[4:0]);
         chk("paused", paused, m_mode == 2);
         chk("wr_ready", wr_ready, m_ready && m_count < DEPTH && !clear && !pend[2][0]);
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [4:0] d);
      wr_valid = 1'b1; wr_data = d;
      @(negedge clk);
      wr_valid = 1'b0;
   endtask

   task automatic key_hold(input int k, input int n);
      keys[k] = 1'b0;
      cyc(n);
      keys[k] = 1'b1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " hex3_hex0"}, hex30, 32'hFFFF_FFFF);
      chk({tag, " hex5_hex4"}, hex54, 16'hFFFF);
      chk({tag, " msg_count"}, msg_count, 0);
      chk({tag, " paused"}, paused, 0);
      chk({tag, " wr_ready"}, wr_ready, 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_n = 1; keys = 4'hF; wr_valid = 0; wr_data = '0; clear = 0;
      #2 rst_n = 0;
      #1 check_on = 1;
      #10 chk_reset_vals("reset");
      @(negedge clk); rst_n = 1;
      @(posedge clk); #1 chk("wr_ready after reset", wr_ready, 1);
      @(negedge clk);

      // Short message, static display.
      wr(5'h01); wr(5'h02); wr(5'h03);
      cyc(2);
      chk("t1 hex5_hex4", hex54, 16'hF9A4);
      chk("t1 hex3_hex0", hex30, 32'hB0FF_FFFF);
      chk("t1 msg_count", msg_count, 3);
      chk("t1 paused", paused, 0);
      clear = 1; cyc(1); clear = 0; cyc(2);
      chk("t1 clear count", msg_count, 0);

      // Ten entries scroll; catch window 7.
      for (int i = 0; i < 10; i++) wr(5'(i));
      n = 0;
      while (hex54[15:8] !== 8'hF8 && n < 400) begin @(negedge clk); n++; end
      chk("t2 win7 reached", n < 400, 1);
      chk("t2 win7 hex5_hex4", hex54, 16'hF880);
      chk("t2 win7 hex3_hex0", hex30, 32'h90C0_F9A4);
      cyc(100);
      wr(5'h0A); wr(5'h1B);
      cyc(30);

      // Pause, step, resume.
      key_hold(0, 10); cyc(2);
      chk("t4 paused", paused, 1);
      cyc(50);
      key_hold(1, 8); cyc(12);
      key_hold(0, 8); cyc(12);
      chk("t4 resumed", paused, 0);
      cyc(30);
      key_hold(0, 8); cyc(12);
      chk("t4 paused again", paused, 1);
      keys[0] = 0; keys[1] = 0; cyc(8); keys = 4'hF; cyc(12);
      chk("t4 key0+key1 resumes", paused, 0);
      key_hold(3, 8); cyc(12);
      chk("t4 key3 ignored", paused, 0);

`ifdef HEX_DEBOUNCE_EN
      // Bouncy KEY0: only the settled low counts.
      for (int b = 0; b < 3; b++) begin
         keys[0] = 0; cyc(2); keys[0] = 1; cyc(2);
      end
      keys[0] = 0;
      repeat (DBC + 3) @(posedge clk);
      #1 chk("t5 not yet paused", paused, 0);
      @(posedge clk); #1 chk("t5 paused once", paused, 1);
      @(negedge clk); cyc(10); keys[0] = 1; cyc(12);
      chk("t5 still paused", paused, 1);
      key_hold(0, 8); cyc(12);
      chk("t5 resumed", paused, 0);
`endif

      // KEY2 clears.
      key_hold(2, 8); cyc(12);
      chk("key2 clear count", msg_count, 0);

      // Full buffer, then clear against a write.
      for (int i = 0; i < DEPTH; i++) wr({i == 5, 4'(i)});
      wr_valid = 1; wr_data = 5'h1F; cyc(5);
      chk("t3 full wr_ready", wr_ready, 0);
      chk("t3 full count", msg_count, 16);
      clear = 1; cyc(1); clear = 0; wr_valid = 0; cyc(2);
      chk("t3 clear count", msg_count, 0);
      chk("t3 clear hex3_hex0", hex30, 32'hFFFF_FFFF);
      chk("t3 clear hex5_hex4", hex54, 16'hFFFF);
      wr(5'h04);
      clear = 1; wr_valid = 1; wr_data = 5'h07; cyc(1); clear = 0; wr_valid = 0; cyc(2);
      chk("t3 clear beats write", msg_count, 0);

      // Asynchronous reset mid-scroll.
      for (int i = 0; i < 8; i++) wr(5'(i));
      cyc(40);
      #2 rst_n = 0;
      #1 chk_reset_vals("t6 async reset");
      @(negedge clk); rst_n = 1;
      cyc(3);
      wr(5'h0C); cyc(3);
      chk("t6 post-reset count", msg_count, 1);
      chk("t6 post-reset hex5_hex4", hex54, 16'hC6FF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
